// File: rtl/sq_dcache_arbiter_pkg.sv
// Shared types for the store-queue / data-cache arbiter slice: the retired-store packet,
// the cache request packet and the retire-stall helper.
package sq_dcache_arbiter_pkg;

    // Local stand-ins for the sys_defs.svh definitions this slice relies on.
    localparam int XLEN = 32;

    typedef struct packed {
        logic            ready;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [3:0]      usebytes;
    } SQ_ENTRY_PACKET;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [3:0]      usebytes;
    } WB_ENTRY_PACKET;

    localparam logic [1:0] DCACHE_SRC_STORE = 2'd0;
    localparam logic [1:0] DCACHE_SRC_LD0   = 2'd1;
    localparam logic [1:0] DCACHE_SRC_LD1   = 2'd2;

    typedef struct packed {
        logic            store;
        logic [1:0]      src;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [3:0]      usebytes;
    } DCACHE_REQ_PACKET;

    // Slot [2] is oldest, so the youngest slots are blocked first as space runs out.
    function automatic logic [2:0] stall_for_free(input int unsigned free);
        if (free < 1)      return 3'b111;
        else if (free < 2) return 3'b011;
        else if (free < 3) return 3'b001;
        else               return 3'b000;
    endfunction

endpackage

// File: rtl/sq_dcache_arbiter_wb_fifo.sv
// Circular write buffer: up to three retired stores in per cycle (oldest first), one out.
// Exposes occupancy and every live entry's address for load-alias checks.
module wb_fifo
    import sq_dcache_arbiter_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  SQ_ENTRY_PACKET [2:0]               enq,
    input  logic                               deq,
    output WB_ENTRY_PACKET                     head,
    output logic [$clog2(DEPTH):0]             count,
    output logic [DEPTH-1:0]                   entry_valid,
    output logic [DEPTH-1:0][XLEN-1:0]         entry_addr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    WB_ENTRY_PACKET   mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] slot_ptr [3];
    logic [1:0]       n_enq;

    // NOTE: always_comb assigns every output before any conditional use, so no latch can form.
    always_comb begin
        n_enq = '0;
        for (int k = 2; k >= 0; k--) begin
            slot_ptr[k] = tail_ptr + PTR_W'(n_enq);
            n_enq       = n_enq + 2'(enq[k].ready);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + PTR_W'(deq);
            tail_ptr <= tail_ptr + PTR_W'(n_enq);
            count    <= count + CNT_W'(n_enq) - CNT_W'(deq);
        end
    end

    // NOTE: the storage array has no reset; entry_valid masks whatever stale data it holds.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (enq[k].ready)
                mem[slot_ptr[k]] <= '{addr: enq[k].addr, data: enq[k].data, usebytes: enq[k].usebytes};
        end
    end

    always_comb begin
        head = mem[head_ptr];
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = {1'b0, PTR_W'(i) - head_ptr} < count;
            entry_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/sq_dcache_arbiter.sv
// Arbitrates the single data-cache port between buffered retired stores and two load ports,
// with high-water and starvation overrides, retire backpressure and load/store alias flags.
module sq_dcache_arbiter
    import sq_dcache_arbiter_pkg::*;
#(
    parameter int WB_DEPTH     = 8,
    parameter int HIGH_WATER   = 6,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                          clock,
    input  logic                          reset,
    input  SQ_ENTRY_PACKET [2:0]          st_in,
    output logic [2:0]                    retire_stall,
    input  logic [1:0]                    ld_req,
    input  logic [1:0][XLEN-1:0]          ld_addr,
    output logic [1:0]                    ld_gnt,
    output logic [1:0]                    ld_conflict,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_req_store,
    output logic [1:0]                    mem_req_src,
    output logic [XLEN-1:0]               mem_req_addr,
    output logic [XLEN-1:0]               mem_req_data,
    output logic [3:0]                    mem_req_usebytes,
    output logic [$clog2(WB_DEPTH):0]     wb_count,
    output logic                          wb_empty
);
    localparam int CNT_W    = $clog2(WB_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {WIN_NONE, WIN_STORE, WIN_LD0, WIN_LD1} winner_e;

    WB_ENTRY_PACKET                head;
    logic [WB_DEPTH-1:0]           entry_valid;
    logic [WB_DEPTH-1:0][XLEN-1:0] entry_addr;
    logic [CNT_W-1:0]              free_slots;
    logic [STARVE_W-1:0]           starve;
    logic [1:0]                    ld_match;
    logic [2:0]                    st_ready;
    logic                          have_store, force_store, store_fire;
    winner_e                       winner;
    DCACHE_REQ_PACKET              req;

    wb_fifo #(.DEPTH(WB_DEPTH)) u_wb (
        .clock       (clock),
        .reset       (reset),
        .enq         (st_in),
        .deq         (store_fire),
        .head        (head),
        .count       (wb_count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    assign free_slots   = CNT_W'(WB_DEPTH) - wb_count;
    assign retire_stall = reset ? 3'b000 : stall_for_free(32'(free_slots));
    assign wb_empty     = (wb_count == '0);
    assign st_ready     = {st_in[2].ready, st_in[1].ready, st_in[0].ready};

    // A load aliases both live buffer entries and stores retiring this very cycle.
    always_comb begin
        ld_match = '0;
        for (int i = 0; i < 2; i++) begin
            for (int e = 0; e < WB_DEPTH; e++)
                if (entry_valid[e] && entry_addr[e] == ld_addr[i]) ld_match[i] = 1'b1;
            for (int k = 0; k < 3; k++)
                if (st_in[k].ready && st_in[k].addr == ld_addr[i]) ld_match[i] = 1'b1;
            ld_match[i] = ld_match[i] & ld_req[i];
        end
    end

    assign ld_conflict = reset ? 2'b00 : ld_match;
    assign have_store  = (wb_count != '0);
    assign force_store = have_store &&
                         (wb_count >= CNT_W'(HIGH_WATER) || starve == STARVE_W'(STARVE_LIMIT));

    always_comb begin
        winner = WIN_NONE;
        if (reset)                            winner = WIN_NONE;
        else if (force_store)                 winner = WIN_STORE;
        else if (ld_req[0] && !ld_match[0])   winner = WIN_LD0;
        else if (ld_req[1] && !ld_match[1])   winner = WIN_LD1;
        else if (have_store)                  winner = WIN_STORE;
    end

    always_comb begin
        req          = '0;
        req.usebytes = 4'b1111;
        unique case (winner)
            WIN_STORE: begin
                req.store    = 1'b1;
                req.src      = DCACHE_SRC_STORE;
                req.addr     = head.addr;
                req.data     = head.data;
                req.usebytes = head.usebytes;
            end
            WIN_LD0: begin
                req.src  = DCACHE_SRC_LD0;
                req.addr = ld_addr[0];
            end
            WIN_LD1: begin
                req.src  = DCACHE_SRC_LD1;
                req.addr = ld_addr[1];
            end
            default: ;
        endcase
    end

    assign mem_req_valid    = (winner != WIN_NONE);
    assign mem_req_store    = req.store;
    assign mem_req_src      = req.src;
    assign mem_req_addr     = req.addr;
    assign mem_req_data     = req.data;
    assign mem_req_usebytes = req.usebytes;
    assign store_fire       = (winner == WIN_STORE) && mem_req_ready;
    assign ld_gnt           = {(winner == WIN_LD1) && mem_req_ready, (winner == WIN_LD0) && mem_req_ready};

    always_ff @(posedge clock) begin
        if (reset || !have_store || store_fire)
            starve <= '0;
        else if (starve != STARVE_W'(STARVE_LIMIT))
            starve <= starve + STARVE_W'(1);
    end

    enq_while_stalled: assert property (@(posedge clock) disable iff (reset)
                                        (st_ready & retire_stall) == 3'b000);

endmodule
